rs_alu_issue_ctrl: RTL and testbench
====================================

// Module: rs_alu_issue_ctrl
// PURPOSE
//  Control block for the ALU reservation station (RS). It owns the per-entry busy vector and
//  allocates free entries to dispatch, raising one-hot write enables into the RS entry array.
//  It collects each entry's ready flag, selects one ready entry per cycle and holds it in an
//  issue register until the ALU accepts it. That handshake frees the entry.
// PARAMETERS
//  ENTRY_NUM  8  number of RS entries
//  ENTRY_SEL  3  index width, equal to clog2(ENTRY_NUM)
// PORTS
//  clk_i         in   1          clock
//  reset_i       in   1          synchronous, active-high reset
//  flush_i       in   1          pipeline kill: drop all entries and the held issue
//  dp_valid_i    in   1          dispatch offers one instruction this cycle
//  dp_ready_o    out  1          a free entry exists and no flush is active
//  dp_idx_o      out  ENTRY_SEL  entry index allocated this cycle
//  we_o          out  ENTRY_NUM  one-hot write enable into the entries (drives each entry's we_i)
//  busy_o        out  ENTRY_NUM  busy vector (drives each entry's busy_i)
//  ready_vec_i   in   ENTRY_NUM  per-entry ready_o (entry busy and both operands valid)
//  issue_valid_o out  1          the issue register holds a selected entry
//  issue_idx_o   out  ENTRY_SEL  held entry index (muxes that entry's operand and control outputs)
//  issue_ready_i in   1          ALU accepts the held entry this cycle
//  free_cnt_o    out  ENTRY_SEL+1 number of entries that are not busy
// BEHAVIOUR
//  Reset (synchronous, active-high): busy=0, issue_valid_o=0, issue_idx_o=0, age matrix=0.
//    Consequently we_o=0, dp_ready_o=1, free_cnt_o=ENTRY_NUM.
//  Allocation:
//   - dp_ready_o = ~flush_i & |(~busy), evaluated on the current-cycle busy vector.
//   - alloc = dp_valid_i & dp_ready_o. The selected entry is the lowest-index free entry;
//     we_o is its one-hot and dp_idx_o is its index.
//   - When alloc is 0, we_o=0 and dp_idx_o=0.
//  Selection (combinational):
//   - cand = busy & ready_vec_i & ~hold.
//   - hold is the one-hot of issue_idx_o when issue_valid_o=1, otherwise 0.
//   - An entry written in cycle N has registered operands, so it cannot be a candidate
//     before cycle N+1.
//  Issue register (1-cycle latency from cand to output):
//   - Load enable = ~issue_valid_o | issue_ready_i.
//   - On load: issue_valid_o <= |cand and issue_idx_o <= the winning index.
//   - Otherwise both hold their values. A stalled ALU therefore keeps the index stable.
//  Free: handshake = issue_valid_o & issue_ready_i clears busy[issue_idx_o] at the clock edge.
//   The entry stays busy while it is held, so dispatch can never overwrite an entry in flight.
//  Busy update: busy_next = (busy | we_o) & ~free_onehot.
//   - A free and an allocation in the same cycle never target the same entry, because
//     allocation uses the pre-free busy vector.
//   - Back-to-back: handshake and a new load happen in the same cycle. Full throughput is
//     one issue per cycle.
//  Flush: on the next edge, busy=0, issue_valid_o=0 and the age matrix is cleared.
//   During flush, we_o=0 and dp_ready_o=0. flush_i takes priority over handshake and alloc.
//  Full: all entries busy gives dp_ready_o=0 and free_cnt_o=0. Issue continues.
//  Empty: cand=0 gives issue_valid_o=0 after the load.
//  free_cnt_o = popcount(~busy), registered state only.
// CONFIGURATION
//  RS_ALU_AGE_ORDER_EN defined:
//   - Oldest-first selection using an ENTRY_NUM x ENTRY_NUM age matrix.
//   - age[i][j]=1 means entry i is older than entry j.
//   - On allocation of entry k: set age[j][k] = busy[j] for every j, and clear row k.
//   - Winner = the cand entry i with no cand j where age[j][i]=1.
//  RS_ALU_AGE_ORDER_EN undefined:
//   - No age matrix. Winner = the lowest-index bit of cand.
// STRUCTURE
//  Shared consts header (consts/RS.vh):
//   - RS_ALU_ENT_NUM, RS_ALU_ENT_SEL.
//   - The one-hot-to-index and popcount functions.
//  Sub-module rs_prio_enc: parameterised lowest-set-bit priority encoder producing a one-hot,
//  an index and an any flag. It is instantiated twice:
//   - on ~busy for allocation;
//   - on cand, or on the age-filtered cand, for selection.
// TESTING
//  1. Reset, then dp_valid_i=1 for 3 cycles -> we_o=0x01,0x02,0x04; busy_o=0x07; free_cnt_o=5.
//  2. Hold ready_vec_i=0x06 with issue_ready_i=0 -> issue_idx_o=1 and it stays 1.
//     Then issue_ready_i=1 -> busy clears bit1 and issue_idx_o=2 on the next cycle.
//  3. Fill all 8 entries -> dp_ready_o=0 and free_cnt_o=0.
//     Handshake entry 3 while dp_valid_i=1 -> that cycle's we_o=0; next cycle we_o=0x08.
//  4. Allocate entries in order 5, 2, 7 with all ready:
//     - with RS_ALU_AGE_ORDER_EN -> issue order 5, 2, 7;
//     - without it -> issue order 2, 5, 7.
//  5. flush_i with issue_valid_o=1 and busy=0xFF, dp_valid_i=1 ->
//     we_o=0 that cycle; next cycle busy_o=0, issue_valid_o=0, free_cnt_o=8.
//  6. Assert reset_i while an issue is held mid-stall -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/rs_alu_issue_ctrl_pkg.sv
// Shared constants and helper functions for the ALU reservation station.
package rs_alu_issue_ctrl_pkg;

   localparam int RS_ALU_ENT_NUM = 8;
   localparam int RS_ALU_ENT_SEL = 3;

   // Index of the set bit in a one-hot vector (0 when no bit is set).
   function automatic logic [RS_ALU_ENT_SEL-1:0] onehot_to_idx(
      input logic [RS_ALU_ENT_NUM-1:0] oh
   );
      logic [RS_ALU_ENT_SEL-1:0] idx;
      idx = '0;
      for (int i = 0; i < RS_ALU_ENT_NUM; i++) begin
         if (oh[i]) idx = idx | RS_ALU_ENT_SEL'(i);
      end
      return idx;
   endfunction

   // Number of set bits in an entry-wide vector.
   function automatic logic [RS_ALU_ENT_SEL:0] popcount(
      input logic [RS_ALU_ENT_NUM-1:0] v
   );
      logic [RS_ALU_ENT_SEL:0] cnt;
      cnt = '0;
      for (int i = 0; i < RS_ALU_ENT_NUM; i++) begin
         cnt = cnt + (RS_ALU_ENT_SEL+1)'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rs_alu_issue_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot of the winner, its index and an any flag.
module rs_prio_enc #(
   parameter int N   = 8,
   parameter int SEL = 3
) (
   input  logic [N-1:0]   req_i,
   output logic [N-1:0]   onehot_o,
   output logic [SEL-1:0] idx_o,
   output logic           any_o
);

   // Scan from the top down so the lowest requesting bit is the last one written.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (req_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            idx_o       = SEL'(i);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/rs_alu_issue_ctrl.sv
// ALU reservation-station control: entry allocation, busy tracking, issue
// selection and the issue register held until the ALU accepts it.
// Optional feature macro: RS_ALU_AGE_ORDER_EN (oldest-first selection via an
// age matrix); without it the lowest-index ready entry wins.
module rs_alu_issue_ctrl
   import rs_alu_issue_ctrl_pkg::*;
#(
   parameter int ENTRY_NUM = RS_ALU_ENT_NUM,
   parameter int ENTRY_SEL = RS_ALU_ENT_SEL
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 flush_i,
   input  logic                 dp_valid_i,
   output logic                 dp_ready_o,
   output logic [ENTRY_SEL-1:0] dp_idx_o,
   output logic [ENTRY_NUM-1:0] we_o,
   output logic [ENTRY_NUM-1:0] busy_o,
   input  logic [ENTRY_NUM-1:0] ready_vec_i,
   output logic                 issue_valid_o,
   output logic [ENTRY_SEL-1:0] issue_idx_o,
   input  logic                 issue_ready_i,
   output logic [ENTRY_SEL:0]   free_cnt_o
);

   logic [ENTRY_NUM-1:0] busy_q;
   logic [ENTRY_NUM-1:0] busy_d;

   // Issue register (stage 1): valid, index and one-hot of the held entry.
   logic                 vld_p1;
   logic [ENTRY_SEL-1:0] idx_p1;
   logic [ENTRY_NUM-1:0] oh_p1;

   logic [ENTRY_NUM-1:0] alloc_oh;
   logic [ENTRY_SEL-1:0] alloc_idx;
   logic                 alloc_any;
   logic                 alloc;

   logic [ENTRY_NUM-1:0] hold;
   logic [ENTRY_NUM-1:0] cand;
   logic [ENTRY_NUM-1:0] sel_req;
   logic [ENTRY_NUM-1:0] sel_oh;
   logic [ENTRY_SEL-1:0] sel_idx;
   logic                 sel_any;

   logic                 load;
   logic                 handshake;
   logic [ENTRY_NUM-1:0] free_oh;

   // Stage 0: allocation picks the lowest free entry from the current busy vector.
   rs_prio_enc #(.N(ENTRY_NUM), .SEL(ENTRY_SEL)) u_alloc_enc (
      .req_i    (~busy_q),
      .onehot_o (alloc_oh),
      .idx_o    (alloc_idx),
      .any_o    (alloc_any)
   );

   assign dp_ready_o = ~flush_i & alloc_any;
   assign alloc      = dp_valid_i & dp_ready_o;
   assign we_o       = alloc ? alloc_oh  : '0;
   assign dp_idx_o   = alloc ? alloc_idx : '0;

   // The held entry stays busy but must not be picked a second time.
   assign hold = vld_p1 ? oh_p1 : '0;
   assign cand = busy_q & ready_vec_i & ~hold;

`ifdef RS_ALU_AGE_ORDER_EN
   // age_q[i][j] = 1 means entry i was allocated before entry j.
   logic [ENTRY_NUM-1:0] age_q [ENTRY_NUM];

   // Keep only candidates that no other candidate is older than.
   always_comb begin
      sel_req = cand;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         for (int j = 0; j < ENTRY_NUM; j++) begin
            if (cand[j] && age_q[j][i]) sel_req[i] = 1'b0;
         end
      end
   end

   // A newly allocated entry is younger than every entry already busy.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         age_q <= '{default: '0};
      end else if (alloc) begin
         for (int j = 0; j < ENTRY_NUM; j++) begin
            age_q[j][alloc_idx] <= busy_q[j];
         end
         age_q[alloc_idx] <= '0;
      end
   end
`else
   assign sel_req = cand;
`endif

   rs_prio_enc #(.N(ENTRY_NUM), .SEL(ENTRY_SEL)) u_sel_enc (
      .req_i    (sel_req),
      .onehot_o (sel_oh),
      .idx_o    (sel_idx),
      .any_o    (sel_any)
   );

   assign load      = ~vld_p1 | issue_ready_i;
   assign handshake = vld_p1 & issue_ready_i;
   assign free_oh   = handshake ? oh_p1 : '0;
   assign busy_d    = (busy_q | we_o) & ~free_oh;

   // Busy vector: set on allocation, cleared on the ALU handshake; flush drops all.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) busy_q <= '0;
      else                    busy_q <= busy_d;
   end

   // Stage 1: issue register reloads when empty or when the ALU takes the held entry.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_p1 <= 1'b0;
         idx_p1 <= '0;
         oh_p1  <= '0;
      end else if (flush_i) begin
         vld_p1 <= 1'b0;
      end else if (load) begin
         vld_p1 <= sel_any;
         idx_p1 <= sel_idx;
         oh_p1  <= sel_oh;
      end
   end

   assign busy_o        = busy_q;
   assign issue_valid_o = vld_p1;
   assign issue_idx_o   = idx_p1;
   assign free_cnt_o    = popcount(~busy_q);

endmodule

// File: tb/tb_rs_alu_issue_ctrl.sv
// Directed bench for rs_alu_issue_ctrl; honours RS_ALU_AGE_ORDER_EN for issue order.
module tb_rs_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       flush_i = 1'b0;
   logic       dp_valid_i = 1'b0;
   logic       dp_ready_o;
   logic [2:0] dp_idx_o;
   logic [7:0] we_o;
   logic [7:0] busy_o;
   logic [7:0] ready_vec_i = '0;
   logic       issue_valid_o;
   logic [2:0] issue_idx_o;
   logic       issue_ready_i = 1'b0;
   logic [3:0] free_cnt_o;

   int n_chk  = 0;
   int n_pass = 0;

   rs_alu_issue_ctrl dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .flush_i       (flush_i),
      .dp_valid_i    (dp_valid_i),
      .dp_ready_o    (dp_ready_o),
      .dp_idx_o      (dp_idx_o),
      .we_o          (we_o),
      .busy_o        (busy_o),
      .ready_vec_i   (ready_vec_i),
      .issue_valid_o (issue_valid_o),
      .issue_idx_o   (issue_idx_o),
      .issue_ready_i (issue_ready_i),
      .free_cnt_o    (free_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int order [3];

   initial begin
`ifdef RS_ALU_AGE_ORDER_EN
      order = '{5, 2, 7};
`else
      order = '{2, 5, 7};
`endif
      // reset
      tick(); tick();
      reset_i = 1'b0;
      #1;
      check("rst_busy",  busy_o, 0);
      check("rst_valid", issue_valid_o, 0);
      check("rst_idx",   issue_idx_o, 0);
      check("rst_we",    we_o, 0);
      check("rst_rdy",   dp_ready_o, 1);
      check("rst_free",  free_cnt_o, 8);

      // 1: three allocations
      dp_valid_i = 1'b1;
      #1;
      check("t1_we0", we_o, 8'h01);
      check("t1_idx0", dp_idx_o, 0);
      tick();
      check("t1_we1", we_o, 8'h02);
      tick();
      check("t1_we2", we_o, 8'h04);
      check("t1_idx2", dp_idx_o, 2);
      tick();
      dp_valid_i = 1'b0;
      #1;
      check("t1_we_idle", we_o, 0);
      check("t1_didx_idle", dp_idx_o, 0);
      check("t1_busy", busy_o, 8'h07);
      check("t1_free", free_cnt_o, 5);
      check("t1_novalid", issue_valid_o, 0);

      // 2: stalled issue holds, then handshake
      ready_vec_i = 8'h06;
      tick();
      check("t2_valid", issue_valid_o, 1);
      check("t2_idx", issue_idx_o, 1);
      tick();
      check("t2_idx_stall", issue_idx_o, 1);
      check("t2_busy_stall", busy_o, 8'h07);
      issue_ready_i = 1'b1;
      tick();
      check("t2_busy_hs", busy_o, 8'h05);
      check("t2_idx_next", issue_idx_o, 2);
      check("t2_valid_next", issue_valid_o, 1);
      ready_vec_i = 8'h00;
      tick();
      issue_ready_i = 1'b0;
      #1;
      check("t2_busy_end", busy_o, 8'h01);
      check("t2_empty", issue_valid_o, 0);

      // 3: fill, full, handshake while dispatching
      dp_valid_i = 1'b1;
      repeat (7) tick();
      check("t3_busy_full", busy_o, 8'hFF);
      check("t3_rdy_full", dp_ready_o, 0);
      check("t3_free_full", free_cnt_o, 0);
      check("t3_we_full", we_o, 0);
      ready_vec_i = 8'h08;
      tick();
      check("t3_issue_full", issue_valid_o, 1);
      check("t3_issue_idx", issue_idx_o, 3);
      ready_vec_i = 8'h00;
      issue_ready_i = 1'b1;
      #1;
      check("t3_we_hs", we_o, 0);
      tick();
      check("t3_we_after", we_o, 8'h08);
      check("t3_didx_after", dp_idx_o, 3);
      check("t3_busy_after", busy_o, 8'hF7);
      check("t3_valid_after", issue_valid_o, 0);
      issue_ready_i = 1'b0;
      tick();
      dp_valid_i = 1'b0;
      #1;
      check("t3_refull", busy_o, 8'hFF);

      // 4: reallocate 5, 2, 7 in that order, then issue all three
      ready_vec_i = 8'h20;
      tick();
      check("t4_pick5", issue_idx_o, 5);
      ready_vec_i = 8'h00; issue_ready_i = 1'b1; dp_valid_i = 1'b1;
      tick();
      check("t4_free5", busy_o, 8'hDF);
      ready_vec_i = 8'h04; issue_ready_i = 1'b0;
      #1;
      check("t4_we5", we_o, 8'h20);
      tick();
      check("t4_pick2", issue_idx_o, 2);
      ready_vec_i = 8'h00; issue_ready_i = 1'b1; dp_valid_i = 1'b0;
      tick();
      dp_valid_i = 1'b1; ready_vec_i = 8'h80; issue_ready_i = 1'b0;
      #1;
      check("t4_we2", we_o, 8'h04);
      tick();
      check("t4_pick7", issue_idx_o, 7);
      ready_vec_i = 8'h00; issue_ready_i = 1'b1; dp_valid_i = 1'b0;
      tick();
      dp_valid_i = 1'b1; issue_ready_i = 1'b0;
      tick();
      dp_valid_i = 1'b0;
      ready_vec_i = 8'hA4; issue_ready_i = 1'b1;
      #1;
      check("t4_busy_pre", busy_o, 8'hFF);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t4_order%0d", k), issue_idx_o, order[k]);
         check($sformatf("t4_vld%0d", k), issue_valid_o, 1);
      end
      tick();
      check("t4_drained", issue_valid_o, 0);
      check("t4_busy_end", busy_o, 8'h5B);
      check("t4_free_end", free_cnt_o, 3);

      // 5: flush with a held issue and a full station
      ready_vec_i = 8'h00; issue_ready_i = 1'b0; dp_valid_i = 1'b1;
      repeat (3) tick();
      check("t5_full", busy_o, 8'hFF);
      ready_vec_i = 8'h01;
      tick();
      check("t5_held", issue_valid_o, 1);
      check("t5_held_idx", issue_idx_o, 0);
      flush_i = 1'b1;
      #1;
      check("t5_we_flush", we_o, 0);
      check("t5_rdy_flush", dp_ready_o, 0);
      tick();
      flush_i = 1'b0; dp_valid_i = 1'b0;
      #1;
      check("t5_busy", busy_o, 0);
      check("t5_valid", issue_valid_o, 0);
      check("t5_free", free_cnt_o, 8);
      flush_i = 1'b1; dp_valid_i = 1'b1;
      #1;
      check("t5_rdy_flush_empty", dp_ready_o, 0);
      check("t5_we_flush_empty", we_o, 0);
      tick();
      flush_i = 1'b0; dp_valid_i = 1'b0;
      #1;
      check("t5_busy_still0", busy_o, 0);

      // 6: reset during a stalled issue
      ready_vec_i = 8'h00; dp_valid_i = 1'b1;
      tick(); tick();
      dp_valid_i = 1'b0; ready_vec_i = 8'h02;
      tick();
      tick();
      check("t6_stall_idx", issue_idx_o, 1);
      check("t6_stall_busy", busy_o, 8'h03);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0; ready_vec_i = 8'h00;
      #1;
      check("t6_busy", busy_o, 0);
      check("t6_valid", issue_valid_o, 0);
      check("t6_idx", issue_idx_o, 0);
      check("t6_we", we_o, 0);
      check("t6_rdy", dp_ready_o, 1);
      check("t6_free", free_cnt_o, 8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
